// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle for rr_hold_arbiter.
// master: requester side (drives req_i); slave: arbiter side (drives the grant).
interface rr_hold_arbiter_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req_i;
    logic [N-1:0]    gnt_o;
    logic            gnt_valid_o;
    logic [IDXW-1:0] gnt_idx_o;

    modport master (
        output req_i,
        input  gnt_o,
        input  gnt_valid_o,
        input  gnt_idx_o
    );

    modport slave (
        input  req_i,
        output gnt_o,
        output gnt_valid_o,
        output gnt_idx_o
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a registered, sticky one-hot grant.
// The owner keeps the grant while its request stays high; on release the
// block re-arbitrates in the same cycle, so there is no idle bubble.
// Optional macro RR_ARB_HOLD_LIMIT_EN caps consecutive ownership at MAX_HOLD
// cycles whenever another requester is waiting.
module rr_hold_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset,
    rr_hold_arbiter_if.slave bus
);
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Reject impossible configurations at elaboration.
    if (N < 1 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_hold_arbiter: N and MAX_HOLD must both be >= 1");
    end

    logic [0:0]      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]   hold_q, hold_d;
    logic [IDXW:0]   pick_oth;
`endif

    logic            owner_req;
    logic            issue;
    logic [IDXW-1:0] win;
    logic [IDXW:0]   pick_all;

    // First set bit of vec scanning start, start+1, ..., wrapping; {found, idx}.
    function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] vec,
                                              input logic [IDXW-1:0] start);
        logic            found;
        logic [IDXW-1:0] idx;
        int unsigned     j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(start) + k;
            if (j >= N) j = j - N;
            if (!found && vec[j]) begin
                found = 1'b1;
                idx   = IDXW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign owner_req = |(bus.req_i & gnt_q);
    assign pick_all  = rr_pick(bus.req_i, ptr_q);

    // Next-state logic: keep, re-arbitrate, or go idle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        issue   = 1'b0;
        win     = '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_d   = hold_q;
        pick_oth = rr_pick(bus.req_i & ~gnt_q, ptr_q);
`endif
        case (state_q)
            IDLE: begin
                if (pick_all[IDXW]) begin
                    issue = 1'b1;
                    win   = pick_all[IDXW-1:0];
                end
            end
            GRANT: begin
                if (owner_req) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
                    if (hold_q == HW'(MAX_HOLD)) begin
                        // Limit reached: hand over if anyone else waits, else retain.
                        if (pick_oth[IDXW]) begin
                            issue = 1'b1;
                            win   = pick_oth[IDXW-1:0];
                        end else begin
                            hold_d = HW'(1);
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
`endif
                end else if (pick_all[IDXW]) begin
                    issue = 1'b1;
                    win   = pick_all[IDXW-1:0];
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        if (issue) begin
            state_d = GRANT;
            valid_d = 1'b1;
            idx_d   = win;
            ptr_d   = (win == IDXW'(N - 1)) ? '0 : win + IDXW'(1);
            for (int unsigned i = 0; i < N; i++) begin
                gnt_d[i] = (win == IDXW'(i));
            end
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_d = HW'(1);
`endif
        end
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = valid_q;
    assign bus.gnt_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: N=4 instance (MAX_HOLD=4) and N=1 instance.
module tb_rr_hold_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.N(4)) bus4 ();
    rr_hold_arbiter_if #(.N(1)) bus1 ();

    rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    rr_hold_arbiter #(.N(1), .MAX_HOLD(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp4(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic v);
        check({tag, ".gnt"},   32'(bus4.gnt_o),       32'(g));
        check({tag, ".idx"},   32'(bus4.gnt_idx_o),   32'(idx));
        check({tag, ".valid"}, 32'(bus4.gnt_valid_o), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        logic [1:0] ei;
        reset      = 1'b1;
        bus4.req_i = 4'b0000;
        bus1.req_i = 1'b0;
        #12;
        exp4("reset", 4'b0000, 2'd0, 1'b0);
        reset      = 1'b0;
        bus4.req_i = 4'b1111;

        // Rotation: each owner drops for the cycle after its grant.
        step(); exp4("rot0", 4'b0001, 2'd0, 1'b1);
        bus4.req_i = 4'b1110;
        step(); exp4("rot1", 4'b0010, 2'd1, 1'b1);
        bus4.req_i = 4'b1101;
        step(); exp4("rot2", 4'b0100, 2'd2, 1'b1);
        bus4.req_i = 4'b1011;
        step(); exp4("rot3", 4'b1000, 2'd3, 1'b1);
        bus4.req_i = 4'b0111;
        step(); exp4("rot_wrap", 4'b0001, 2'd0, 1'b1);

        // Release with nothing pending -> idle (ptr now 1).
        bus4.req_i = 4'b0000;
        step(); exp4("idle", 4'b0000, 2'd0, 1'b0);

        // Grant to 2, sticky against other requests, then release; ptr=3 scans 3,0.
        bus4.req_i = 4'b0100;
        step(); exp4("g2", 4'b0100, 2'd2, 1'b1);
        bus4.req_i = 4'b1111;
        step(); exp4("g2_sticky", 4'b0100, 2'd2, 1'b1);
        bus4.req_i = 4'b0011;
        step(); exp4("wrap_scan", 4'b0001, 2'd0, 1'b1);

        // Owner 0 releases, 2 wins (ptr=1 scans 1,2); then reset between edges.
        bus4.req_i = 4'b0100;
        step(); exp4("pre_rst", 4'b0100, 2'd2, 1'b1);
        #3 reset = 1'b1;
        #1 exp4("async_rst", 4'b0000, 2'd0, 1'b0);
        #1 reset = 1'b0;
        bus4.req_i = 4'b1111;
        step(); exp4("post_rst", 4'b0001, 2'd0, 1'b1);

        // req=0011 held from owner 0: sticky, or limited to 4 cycles per owner.
        bus4.req_i = 4'b0011;
        for (int c = 1; c < 12; c++) begin
            step();
            e  = 4'b0001;
            ei = 2'd0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            if (c >= 4 && c < 8) begin
                e  = 4'b0010;
                ei = 2'd1;
            end
`endif
            exp4($sformatf("hold0011_c%0d", c), e, ei, 1'b1);
        end

        // Lone requester keeps the grant across the limit boundary.
        bus4.req_i = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            exp4($sformatf("lone_c%0d", c), 4'b0001, 2'd0, 1'b1);
        end

        // Owner 1 then drops with nothing else pending.
        bus4.req_i = 4'b0010;
        step(); exp4("g1", 4'b0010, 2'd1, 1'b1);
        bus4.req_i = 4'b0000;
        step(); exp4("g1_drop", 4'b0000, 2'd0, 1'b0);

        // N=1: grant follows request one cycle later.
        bus1.req_i = 1'b1;
        step();
        check("n1_a.gnt",   32'(bus1.gnt_o),       32'd1);
        check("n1_a.valid", 32'(bus1.gnt_valid_o), 32'd1);
        check("n1_a.idx",   32'(bus1.gnt_idx_o),   32'd0);
        bus1.req_i = 1'b0;
        step();
        check("n1_b.gnt",   32'(bus1.gnt_o),       32'd0);
        check("n1_b.valid", 32'(bus1.gnt_valid_o), 32'd0);
        bus1.req_i = 1'b1;
        step();
        check("n1_c.gnt",   32'(bus1.gnt_o),       32'd1);
        check("n1_c.idx",   32'(bus1.gnt_idx_o),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
